fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 22 ++
 rtl/fifo_wr_arbiter_if.sv | 30 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 145 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types, default widths and a width helper for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_DW           = 8;
  localparam int DEF_MAX_BURST    = 8;
  localparam int DEF_IDLE_TIMEOUT = 16;

  // Bits needed to hold the values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO write-side bundle of the arbiter; master drives the requests, slave is the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = fifo_arb_pkg::DEF_NUM_REQ,
  parameter int DW      = fifo_arb_pkg::DEF_DW
);
  import fifo_arb_pkg::*;

  localparam int GW = clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_last;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  fifo_full;
  logic                  fifo_wr_en;
  logic [DW-1:0]         fifo_din;
  logic [GW-1:0]         grant_id;
  logic                  busy;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr_en, fifo_din, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr_en, fifo_din, grant_id, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: picks the first set bit of req_i
// searching rr_ptr_i+1, rr_ptr_i+2, ... modulo NUM_REQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int GW     = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GW-1:0]      rr_ptr_i,
  output logic [GW-1:0]      sel_o,
  output logic               any_valid_o
);

  logic [GW-1:0] idx;

  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment, so no latch is inferred.
    idx         = '0;
    sel_o       = rr_ptr_i;
    any_valid_o = |req_i;
    // Walk from the farthest candidate to the nearest so the nearest valid one wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = GW'((int'(rr_ptr_i) + k) % NUM_REQ);
      if (req_i[idx]) sel_o = idx;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter sharing the FIFO write port between NUM_REQ requesters.
// Optional: define FIFO_ARB_TIMEOUT_EN to release a grant after IDLE_TIMEOUT idle-valid cycles.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int DW           = DEF_DW,
  parameter int MAX_BURST    = DEF_MAX_BURST,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input logic              clk,
  input logic              rst,
  fifo_wr_arbiter_if.slave arb
);

  localparam int GW = clog2(NUM_REQ);
  localparam int BW = clog2(MAX_BURST + 1);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("fifo_wr_arbiter: NUM_REQ must be 2..8");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("fifo_wr_arbiter: MAX_BURST must be 1..255");
  end
  if (IDLE_TIMEOUT < 1) begin : g_bad_idle_timeout
    $error("fifo_wr_arbiter: IDLE_TIMEOUT must be at least 1");
  end

  arb_state_e         state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]      beat_cnt_q, beat_cnt_d;

  logic [GW-1:0]      pick_sel;
  logic               pick_any;
  logic [DW-1:0]      req_data_arr [NUM_REQ];
  logic [DW-1:0]      g_data;
  logic               g_valid;
  logic               g_last;
  logic               busy;
  logic               transfer;
  logic               burst_done;
  logic [NUM_REQ-1:0] req_ready;
  logic [DW-1:0]      fifo_din;

`ifdef FIFO_ARB_TIMEOUT_EN
  localparam int IW = clog2(IDLE_TIMEOUT + 1);
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req_i       (arb.req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .sel_o       (pick_sel),
    .any_valid_o (pick_any)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) req_data_arr[i] = arb.req_data[i*DW +: DW];
  end

  assign g_data     = req_data_arr[grant_q];
  assign g_valid    = arb.req_valid[grant_q];
  assign g_last     = arb.req_last[grant_q];
  assign busy       = (state_q == GRANT);
  assign transfer   = busy && g_valid && !arb.fifo_full;
  assign burst_done = ((beat_cnt_q + BW'(1)) == BW'(MAX_BURST));

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    req_ready  = '0;
    fifo_din   = '0;
`ifdef FIFO_ARB_TIMEOUT_EN
    idle_cnt_d = idle_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d    = pick_sel;
          beat_cnt_d = '0;
          state_d    = GRANT;
`ifdef FIFO_ARB_TIMEOUT_EN
          idle_cnt_d = '0;
`endif
        end
      end
      GRANT: begin
        req_ready[grant_q] = !arb.fifo_full;
        fifo_din           = g_data;
        if (transfer) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (g_last || burst_done) begin
            state_d  = IDLE;
            rr_ptr_d = grant_q;
          end
        end
`ifdef FIFO_ARB_TIMEOUT_EN
        // Only owner-idle cycles count; a full-stalled but valid owner keeps its count.
        if (transfer) begin
          idle_cnt_d = '0;
        end else if (!g_valid) begin
          idle_cnt_d = idle_cnt_q + IW'(1);
          if (idle_cnt_d == IW'(IDLE_TIMEOUT)) begin
            state_d  = IDLE;
            rr_ptr_d = grant_q;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= GW'(NUM_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the pre-edge values of the others.
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef FIFO_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idle_cnt_q <= '0;
    else      idle_cnt_q <= idle_cnt_d;
  end
`endif

  assign arb.req_ready  = req_ready;
  assign arb.fifo_wr_en = transfer;
  assign arb.fifo_din   = fifo_din;
  assign arb.grant_id   = grant_q;
  assign arb.busy       = busy;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed scoreboard bench for fifo_wr_arbiter; the last step follows FIFO_ARB_TIMEOUT_EN.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int NUM_REQ      = 4;
  localparam int DW           = 8;
  localparam int MAX_BURST    = 8;
  localparam int IDLE_TIMEOUT = 16;
  localparam int GW           = clog2(NUM_REQ);

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [GW-1:0] src;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DW(DW)) arb_if ();

  fifo_wr_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .DW           (DW),
    .MAX_BURST    (MAX_BURST),
    .IDLE_TIMEOUT (IDLE_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .arb (arb_if)
  );

  always #5 clk = ~clk;

  beat_t src_q [NUM_REQ][$];
  exp_t  exp_q [$];
  int    total   = 0;
  int    bad     = 0;
  int    wr_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int src, input logic [DW-1:0] d, input logic last);
    src_q[src].push_back('{d, last});
  endtask

  task automatic expect_beat(input int src, input logic [DW-1:0] d);
    exp_q.push_back('{GW'(src), d});
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    check({tag, "_drain"}, exp_q.size(), 0);
    repeat (3) tick();
  endtask

  task automatic wait_writes(input int n, input string tag);
    int target;
    int c;
    target = wr_seen + n;
    c = 0;
    while (wr_seen < target && c < 200) begin
      tick();
      c++;
    end
    check({tag, "_wait"}, 32'(wr_seen >= target), 1);
  endtask

  // Asserts rst for two cycles, checking that outputs clear without a clock edge.
  task automatic pulse_reset(input string tag);
    tick();
    rst = 1'b0;
    #1;
    check({tag, "_rst_busy"},  32'(arb_if.busy), 0);
    check({tag, "_rst_wr_en"}, 32'(arb_if.fifo_wr_en), 0);
    check({tag, "_rst_ready"}, 32'(arb_if.req_ready), 0);
    check({tag, "_rst_din"},   32'(arb_if.fifo_din), 0);
    check({tag, "_rst_grant"}, 32'(arb_if.grant_id), 0);
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    exp_q.delete();
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Requester model plus write monitor: handshakes are judged at negedge, beats advance after posedge.
  initial begin
    logic [NUM_REQ-1:0] fire;
    exp_t               e;
    beat_t              head;
    arb_if.req_valid = '0;
    arb_if.req_data  = '0;
    arb_if.req_last  = '0;
    forever begin
      @(negedge clk);
      fire = arb_if.req_valid & arb_if.req_ready;
      if (rst && arb_if.fifo_wr_en) begin
        wr_seen++;
        total++;
        assert (exp_q.size() != 0)
        else begin
          bad++;
          $error("FAIL unexpected_write: observed din=0x%0h grant=%0d expected no write",
                 arb_if.fifo_din, arb_if.grant_id);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_din", 32'(arb_if.fifo_din), 32'(e.data));
          check("wr_src", 32'(arb_if.grant_id), 32'(e.src));
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (fire[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        if (src_q[i].size() != 0) begin
          head                       = src_q[i][0];
          arb_if.req_valid[i]        = 1'b1;
          arb_if.req_data[i*DW +: DW] = head.data;
          arb_if.req_last[i]         = head.last;
        end else begin
          arb_if.req_valid[i]        = 1'b0;
          arb_if.req_data[i*DW +: DW] = '0;
          arb_if.req_last[i]         = 1'b0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic v0 [10];
    logic bs [10];
    logic we [10];
    logic [GW-1:0] gi [10];
    int v;
    int hold;

    arb_if.fifo_full = 1'b0;
    rst = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy",  32'(arb_if.busy), 0);
    check("reset_grant", 32'(arb_if.grant_id), 0);
    check("reset_wr_en", 32'(arb_if.fifo_wr_en), 0);
    check("reset_ready", 32'(arb_if.req_ready), 0);
    check("reset_din",   32'(arb_if.fifo_din), 0);
    tick();
    rst = 1'b1;
    tick();

    // Single requester, 3-beat packet with cycle-exact timing
    send(0, 8'h11, 1'b0);
    send(0, 8'h22, 1'b0);
    send(0, 8'h33, 1'b1);
    expect_beat(0, 8'h11);
    expect_beat(0, 8'h22);
    expect_beat(0, 8'h33);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      v0[k] = arb_if.req_valid[0];
      bs[k] = arb_if.busy;
      we[k] = arb_if.fifo_wr_en;
      gi[k] = arb_if.grant_id;
    end
    v = 1;
    for (int k = 4; k >= 0; k--) if (v0[k]) v = k;
    check("t1_idle_no_write", 32'(we[v]), 0);
    check("t1_idle_not_busy", 32'(bs[v]), 0);
    check("t1_grant_id",      32'(gi[v+1]), 0);
    check("t1_busy",          32'(bs[v+1]), 1);
    for (int j = 1; j <= 3; j++) check("t1_wr_en_beat", 32'(we[v+j]), 1);
    check("t1_back_idle",     32'(bs[v+4]), 0);
    check("t1_no_4th_write",  32'(we[v+4]), 0);
    drain("t1");

    // All four continuously valid with 1-beat packets: 0,1,2,3 repeating
    pulse_reset("t2pre");
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        send(k, 8'(8'h80 + k*16 + r), 1'b1);
        expect_beat(k, 8'(8'h80 + k*16 + r));
      end
    end
    drain("t2");

    // req2 streams 20 beats; others hold two 1-beat packets each (pointer is now 3)
    for (int j = 0; j < 20; j++) send(2, 8'(8'h40 + j), (j == 19));
    for (int r = 0; r < 2; r++) begin
      send(0, 8'(8'hC0 + r), 1'b1);
      send(1, 8'(8'hD0 + r), 1'b1);
      send(3, 8'(8'hF0 + r), 1'b1);
    end
    for (int g = 0; g < 2; g++) begin
      expect_beat(0, 8'(8'hC0 + g));
      expect_beat(1, 8'(8'hD0 + g));
      for (int j = 0; j < MAX_BURST; j++) expect_beat(2, 8'(8'h40 + g*MAX_BURST + j));
      expect_beat(3, 8'(8'hF0 + g));
    end
    for (int j = 16; j < 20; j++) expect_beat(2, 8'(8'h40 + j));
    drain("t3");

    // fifo_full for 5 cycles mid-packet (pointer is now 2, so req1 wins)
    for (int j = 0; j < 6; j++) begin
      send(1, 8'(8'hA0 + j), (j == 5));
      expect_beat(1, 8'(8'hA0 + j));
    end
    wait_writes(2, "t4");
    arb_if.fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4_stall_wr_en", 32'(arb_if.fifo_wr_en), 0);
      check("t4_stall_ready", 32'(arb_if.req_ready), 0);
      check("t4_stall_busy",  32'(arb_if.busy), 1);
    end
    tick();
    arb_if.fifo_full = 1'b0;
    drain("t4");

    // Reset mid-burst, then arbitration restarts from requester 0
    for (int j = 0; j < 6; j++) begin
      send(2, 8'(8'h50 + j), (j == 5));
      expect_beat(2, 8'(8'h50 + j));
    end
    wait_writes(2, "t5");
    pulse_reset("t5");
    send(2, 8'h5E, 1'b1);
    send(0, 8'h0A, 1'b0);
    send(0, 8'h0B, 1'b1);
    expect_beat(0, 8'h0A);
    expect_beat(0, 8'h0B);
    expect_beat(2, 8'h5E);
    drain("t5");

    // req1 granted then idles while req3 waits
    pulse_reset("t6pre");
    send(1, 8'h61, 1'b0);
    send(3, 8'h63, 1'b1);
    expect_beat(1, 8'h61);
`ifdef FIFO_ARB_TIMEOUT_EN
    expect_beat(3, 8'h63);
    drain("t6");
`else
    drain("t6");
    hold = wr_seen;
    repeat (40) tick();
    check("t6_hold_busy",   32'(arb_if.busy), 1);
    check("t6_hold_grant",  32'(arb_if.grant_id), 1);
    check("t6_hold_ready",  32'(arb_if.req_ready), 32'h2);
    check("t6_no_write",    wr_seen, hold);
    pulse_reset("t6post");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
